// File: rtl/mc_ctrl_fsm_if.sv
// Memory-side handshake bundle between the multi-cycle controller and its
// instruction/data memories.
interface mc_ctrl_fsm_if;
    logic       imem_req;
    logic       imem_ack;
    logic [3:0] opcode;
    logic       dmem_req;
    logic       dmem_ack;
    logic       mem_write;

    modport master (
        output imem_req, dmem_req, mem_write,
        input  imem_ack, dmem_ack, opcode
    );

    modport slave (
        input  imem_req, dmem_req, mem_write,
        output imem_ack, dmem_ack, opcode
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM with fetch/data-memory timeouts and sticky HALT/ERR.
// Define MC_CTRL_PERF_EN to add the 16-bit retired-instruction counter instr_count.
module mc_ctrl_fsm #(
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    mc_ctrl_fsm_if.master mem,
    output logic          ir_we,
    output logic          pc_we,
    output logic          pc_select,
    output logic          src2_select,
    output logic          alu_out_select,
    output logic          reg_write,
    output logic [1:0]    alu_signal,
    output logic          busy,
    output logic          halted,
    output logic          err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [15:0]   instr_count
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_e;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_write;
        logic       ir_we;
        logic       pc_we;
        logic       pc_select;
        logic       src2_select;
        logic       alu_out_select;
        logic       reg_write;
        logic [1:0] alu_signal;
        logic       busy;
        logic       halted;
        logic       err;
    } ctrl_t;

    state_e     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic [7:0] wait_q, wait_d;
    logic       eoi;
    ctrl_t      ctrl_q;

    // Moore decode; SW holds pc_we across MEM so the PC commits on the acked cycle.
    function automatic ctrl_t ctrl_for(state_e s, logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.imem_req = 1'b1;
                c.ir_we    = 1'b1;
                c.busy     = 1'b1;
            end
            DECODE: begin
                c.busy      = 1'b1;
                c.pc_we     = (op == OP_JMP);
                c.pc_select = (op == OP_JMP);
            end
            EXEC: begin
                c.busy        = 1'b1;
                c.src2_select = op inside {OP_ADDI, OP_LW, OP_SW};
                case (op)
                    OP_SUB:  c.alu_signal = 2'b01;
                    OP_AND:  c.alu_signal = 2'b10;
                    OP_OR:   c.alu_signal = 2'b11;
                    default: c.alu_signal = 2'b00;
                endcase
            end
            MEM: begin
                c.busy      = 1'b1;
                c.dmem_req  = 1'b1;
                c.mem_write = (op == OP_SW);
                c.pc_we     = (op == OP_SW);
            end
            WB: begin
                c.busy           = 1'b1;
                c.reg_write      = 1'b1;
                c.pc_we          = 1'b1;
                c.alu_out_select = (op == OP_LW);
            end
            HALT:    c.halted = 1'b1;
            ERR:     c.err    = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        wait_d   = wait_q;
        eoi      = 1'b0;
        case (state_q)
            IDLE: if (run) state_d = FETCH;
            FETCH: begin
                if (mem.imem_ack) begin
                    opcode_d = mem.opcode;
                    state_d  = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DECODE: begin
                case (opcode_q)
                    OP_JMP:  eoi     = 1'b1;
                    OP_HALT: state_d = HALT;
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_LW, OP_SW: state_d = EXEC;
                    default: state_d = ERR;
                endcase
            end
            EXEC: state_d = (opcode_q inside {OP_LW, OP_SW}) ? MEM : WB;
            MEM: begin
                if (mem.dmem_ack) begin
                    if (opcode_q == OP_SW) eoi = 1'b1;
                    else                   state_d = WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WB:      eoi = 1'b1;
            default: state_d = state_q;
        endcase
        if (eoi) state_d = run ? FETCH : IDLE;
        if (state_d != state_q) wait_d = '0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            wait_q   <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
            ctrl_q   <= ctrl_for(state_d, opcode_d);
        end
    end

    assign mem.imem_req   = ctrl_q.imem_req;
    assign mem.dmem_req   = ctrl_q.dmem_req;
    assign mem.mem_write  = ctrl_q.mem_write;
    assign ir_we          = ctrl_q.ir_we;
    assign pc_we          = ctrl_q.pc_we;
    assign pc_select      = ctrl_q.pc_select;
    assign src2_select    = ctrl_q.src2_select;
    assign alu_out_select = ctrl_q.alu_out_select;
    assign reg_write      = ctrl_q.reg_write;
    assign alu_signal     = ctrl_q.alu_signal;
    assign busy           = ctrl_q.busy;
    assign halted         = ctrl_q.halted;
    assign err            = ctrl_q.err;

`ifdef MC_CTRL_PERF_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (rstn)     count_q <= '0;
        else if (eoi) count_q <= count_q + 16'd1;
    end

    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: each instruction is expanded into its
// expected per-cycle output trace from the opcode class and the ack delays.
module tb_mc_ctrl_fsm;
    localparam int TO = 8;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3;
    localparam logic [3:0] ADDI = 4'h4, LW = 4'h5, SW = 4'h6, JMP = 4'h7, HLT = 4'hF;

    localparam int B_IMEM = 13, B_DMEM = 12, B_MW = 11, B_IRWE = 10, B_PCWE = 9;
    localparam int B_PCSEL = 8, B_SRC2 = 7, B_AOS = 6, B_RW = 5, B_ALU1 = 4;
    localparam int B_ALU0 = 3, B_BUSY = 2, B_HALT = 1, B_ERR = 0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        run;
    logic        ir_we, pc_we, pc_select, src2_select, alu_out_select, reg_write;
    logic [1:0]  alu_signal;
    logic        busy, halted, err;
`ifdef MC_CTRL_PERF_EN
    logic [15:0] instr_count;
`endif

    int nCompared   = 0;
    int nMismatched = 0;
    int perfModel   = 0;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .run            (run),
        .mem            (bus),
        .ir_we          (ir_we),
        .pc_we          (pc_we),
        .pc_select      (pc_select),
        .src2_select    (src2_select),
        .alu_out_select (alu_out_select),
        .reg_write      (reg_write),
        .alu_signal     (alu_signal),
        .busy           (busy),
        .halted         (halted),
        .err            (err)
`ifdef MC_CTRL_PERF_EN
        ,
        .instr_count    (instr_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [13:0] observed();
        return {bus.imem_req, bus.dmem_req, bus.mem_write, ir_we, pc_we, pc_select,
                src2_select, alu_out_select, reg_write, alu_signal, busy, halted, err};
    endfunction

    task automatic applyStimulus(input logic iAck, input logic dAck, input logic runV,
                                 input logic [3:0] op);
        bus.imem_ack = iAck;
        bus.dmem_ack = dAck;
        bus.opcode   = op;
        run          = runV;
    endtask

    task automatic checkOutput(input logic [13:0] e, input string tag);
        logic [13:0] o;
        o = observed();
        nCompared++;
        assert (o === e) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic checkCount(input string tag);
`ifdef MC_CTRL_PERF_EN
        nCompared++;
        assert (instr_count === 16'(perfModel)) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, instr_count, 16'(perfModel));
        end
`else
        if (tag.len() == 0) $display("[TB] unnamed count check");
`endif
    endtask

    // One clock: drive just after the edge, check mid-cycle, advance.
    task automatic runCycle(input logic iAck, input logic dAck, input logic runV,
                            input logic [3:0] op, input logic [13:0] e, input string tag);
        applyStimulus(iAck, dAck, runV, op);
        @(negedge clk);
        checkOutput(e, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic runV);
        runCycle(rb(), rb(), runV, r4(), 14'b0, "idle");
    endtask

    task automatic stickyCycles(input logic [13:0] e, input int n, input string tag);
        for (int i = 0; i < n; i++) runCycle(rb(), rb(), rb(), r4(), e, tag);
    endtask

    task automatic applyReset();
        rstn = 1'b1;
        applyStimulus(rb(), rb(), rb(), r4());
        @(posedge clk);
        #1;
        perfModel = 0;
        @(negedge clk);
        checkOutput(14'b0, "reset_outputs");
        checkCount("reset_count");
        @(posedge clk);
        #1;
        rstn = 1'b0;
    endtask

    // Expected trace of one instruction, starting in its first FETCH cycle.
    task automatic runInstr(input logic [3:0] op, input int fDelay, input int mDelay,
                            input logic runAfter);
        logic [13:0] e;
        logic [1:0]  alu;
        bit isR, isImm, isLw, isSw, isJmp, alive;
        isR   = op inside {ADD, SUB, AND_, OR_};
        isLw  = (op == LW);
        isSw  = (op == SW);
        isImm = op inside {ADDI, LW, SW};
        isJmp = (op == JMP);
        alive = 1;
        case (op)
            SUB:     alu = 2'b01;
            AND_:    alu = 2'b10;
            OR_:     alu = 2'b11;
            default: alu = 2'b00;
        endcase

        for (int i = 0; i <= fDelay && i < TO; i++) begin
            e = '0; e[B_IMEM] = 1; e[B_IRWE] = 1; e[B_BUSY] = 1;
            runCycle(i == fDelay, rb(), rb(), (i == fDelay) ? op : r4(), e, "fetch");
        end
        if (fDelay >= TO) alive = 0;

        if (alive) begin
            e = '0; e[B_BUSY] = 1;
            if (isJmp) begin e[B_PCWE] = 1; e[B_PCSEL] = 1; end
            runCycle(rb(), rb(), isJmp ? runAfter : rb(), r4(), e, "decode");
            if (isJmp) begin
                perfModel++;
                alive = 0;
            end else if (!(isR || isImm)) begin
                alive = 0;
            end
        end

        if (alive) begin
            e = '0; e[B_BUSY] = 1; e[B_SRC2] = isImm; e[B_ALU1] = alu[1]; e[B_ALU0] = alu[0];
            runCycle(rb(), rb(), rb(), r4(), e, "exec");
        end

        if (alive && (isLw || isSw)) begin
            for (int i = 0; i <= mDelay && i < TO; i++) begin
                e = '0; e[B_BUSY] = 1; e[B_DMEM] = 1; e[B_MW] = isSw; e[B_PCWE] = isSw;
                runCycle(rb(), i == mDelay, (isSw && i == mDelay) ? runAfter : rb(), r4(),
                         e, "mem");
            end
            if (mDelay >= TO) begin
                alive = 0;
            end else if (isSw) begin
                perfModel++;
                alive = 0;
            end
        end

        if (alive) begin
            e = '0; e[B_BUSY] = 1; e[B_RW] = 1; e[B_PCWE] = 1; e[B_AOS] = isLw;
            runCycle(rb(), rb(), runAfter, r4(), e, "wb");
            perfModel++;
        end
        checkCount("instr_count");
    endtask

    initial begin
        logic [3:0]  legalOps [8];
        logic [13:0] errV, haltV;
        bit          inIdle;
        logic        ra;
        legalOps = '{ADD, SUB, AND_, OR_, ADDI, LW, SW, JMP};
        errV  = '0; errV[B_ERR]   = 1;
        haltV = '0; haltV[B_HALT] = 1;

        rstn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        applyReset();
        idleCycle(1'b0);
        idleCycle(1'b0);

        $display("[TB] directed instructions");
        idleCycle(1'b1); runInstr(ADD, 0, 0, 1'b0); idleCycle(1'b0);
        idleCycle(1'b1); runInstr(LW, 0, 3, 1'b0); idleCycle(1'b0);
        idleCycle(1'b1); runInstr(JMP, 0, 0, 1'b0); idleCycle(1'b0);
        idleCycle(1'b1);
        runInstr(SUB, 2, 0, 1'b1);
        runInstr(SW, 1, TO - 1, 1'b1);
        runInstr(ADDI, TO - 1, 0, 1'b1);
        runInstr(AND_, 0, 0, 1'b1);
        runInstr(OR_, 0, 0, 1'b0);
        idleCycle(1'b0);

        $display("[TB] randomized instruction stream");
        inIdle = 1;
        for (int n = 0; n < 40; n++) begin
            if (inIdle) idleCycle(1'b1);
            ra = (n == 39) ? 1'b0 : rb();
            runInstr(legalOps[$urandom_range(0, 7)], $urandom_range(0, TO - 1),
                     $urandom_range(0, TO - 1), ra);
            inIdle = !ra;
            if (inIdle) idleCycle(1'b0);
        end

        $display("[TB] fetch timeout");
        idleCycle(1'b1);
        runInstr(ADD, TO, 0, 1'b0);
        stickyCycles(errV, 5, "fetch_timeout_err");
        applyReset();

        $display("[TB] data timeout");
        idleCycle(1'b1);
        runInstr(LW, 0, TO, 1'b0);
        stickyCycles(errV, 4, "mem_timeout_err");
        applyReset();

        $display("[TB] illegal opcode and halt");
        idleCycle(1'b1);
        runInstr(4'b1010, 0, 0, 1'b0);
        stickyCycles(errV, 5, "illegal_err");
        applyReset();
        idleCycle(1'b1);
        runInstr(ADD, 0, 0, 1'b1);
        runInstr(HLT, 1, 0, 1'b1);
        stickyCycles(haltV, 5, "halt_sticky");
        applyReset();

        $display("[TB] reset during SW data wait");
        idleCycle(1'b1);
        runInstr(ADDI, 0, 0, 1'b1);
        begin
            logic [13:0] e;
            e = '0; e[B_IMEM] = 1; e[B_IRWE] = 1; e[B_BUSY] = 1;
            runCycle(1'b1, 1'b0, 1'b1, SW, e, "sw_fetch");
            e = '0; e[B_BUSY] = 1;
            runCycle(1'b0, 1'b0, 1'b1, r4(), e, "sw_decode");
            e = '0; e[B_BUSY] = 1; e[B_SRC2] = 1;
            runCycle(1'b0, 1'b0, 1'b1, r4(), e, "sw_exec");
            e = '0; e[B_BUSY] = 1; e[B_DMEM] = 1; e[B_MW] = 1; e[B_PCWE] = 1;
            runCycle(1'b0, 1'b0, 1'b1, r4(), e, "sw_mem");
        end
        applyReset();
        idleCycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
